// File: rtl/bridge_pkg.sv
// Shared types for the AXI-FIFO to APB bridge scheduler.
// Struct layouts match the default 4/32/32 FIFO word packing.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wreq_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
  } rreq_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rresp_t;

endpackage

// File: rtl/bridge_sched_if.sv
// APB bus between the bridge scheduler (master) and a peripheral (slave).
// Signal names keep the scheduler-side _o/_i suffixes.
interface bridge_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   paddr_o;
  logic                psel_o;
  logic                penable_o;
  logic                pwrite_o;
  logic [DATA_W-1:0]   pwdata_o;
  logic [DATA_W/8-1:0] pstrb_o;
  logic [DATA_W-1:0]   prdata_i;
  logic                pready_i;
  logic                pslverr_i;

  modport master (
    output paddr_o, psel_o, penable_o,
    output pwrite_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    input  paddr_o, psel_o, penable_o,
    input  pwrite_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/bridge_rr_arb.sv
// Two-way round-robin arbiter; bit 0 = write, bit 1 = read.
// Ties go to the side opposite the last grant; reset favours write.
module bridge_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);
  logic last_rd_q;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last_rd_q ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_rd_q <= 1'b1;
    else if (update)
      last_rd_q <= grant[1];
  end
endmodule

// File: rtl/bridge_sched.sv
// Schedules AXI write/read FIFO requests onto one APB master port.
// Define BRIDGE_SCHED_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles.
module bridge_sched
  import bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wreq_empty_i,
  output logic                                   wreq_rden_o,
  input  logic [ID_W+ADDR_W+DATA_W+DATA_W/8-1:0] wreq_rdata_i,
  input  logic                                   rreq_empty_i,
  output logic                                   rreq_rden_o,
  input  logic [ID_W+ADDR_W-1:0]                 rreq_rdata_i,
  input  logic                                   bresp_full_i,
  output logic                                   bresp_wren_o,
  output logic [ID_W+1:0]                        bresp_wdata_o,
  input  logic                                   rresp_full_i,
  output logic                                   rresp_wren_o,
  output logic [ID_W+DATA_W+1:0]                 rresp_wdata_o,
  bridge_sched_if.master                         apb
);
  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be positive");
  end

  state_e state, state_nxt;

  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              write_q;

  logic [1:0]        req, gnt;
  logic              take, done, push, tout;
  logic [1:0]        resp;
  logic [DATA_W-1:0] rdata;

  assign req[0] = !wreq_empty_i && !bresp_full_i;
  assign req[1] = !rreq_empty_i && !rresp_full_i;
  assign take   = rst_n && (state == IDLE) && (gnt != 2'b00);

  bridge_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (take),
    .grant  (gnt)
  );

  assign wreq_rden_o = take && gnt[0];
  assign rreq_rden_o = take && gnt[1];

`ifdef BRIDGE_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || state != ACCESS)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

  assign tout = (state == ACCESS) && !apb.pready_i &&
                (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tout = 1'b0;
`endif

  assign done = (state == ACCESS) && (apb.pready_i || tout);
  // Reset wins over a completing beat: the popped request is dropped.
  assign push = rst_n && done;
  assign resp = (apb.pready_i && !apb.pslverr_i) ? RESP_OKAY
                                                 : RESP_SLVERR;
  assign rdata = apb.pready_i ? apb.prdata_i : '0;

  assign bresp_wren_o  = push && write_q;
  assign rresp_wren_o  = push && !write_q;
  assign bresp_wdata_o = bresp_wren_o ? {id_q, resp} : '0;
  assign rresp_wdata_o = rresp_wren_o ? {id_q, rdata, resp} : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
    end else if (take) begin
      write_q <= gnt[0];
      if (gnt[0]) begin
        {id_q, addr_q, wdata_q, strb_q} <= wreq_rdata_i;
      end else begin
        {id_q, addr_q} <= rreq_rdata_i;
        wdata_q        <= '0;
        strb_q         <= '0;
      end
    end
  end

  assign apb.psel_o    = (state != IDLE);
  assign apb.penable_o = (state == ACCESS);
  assign apb.paddr_o   = addr_q;
  assign apb.pwrite_o  = write_q;
  assign apb.pwdata_o  = wdata_q;
  assign apb.pstrb_o   = strb_q;
endmodule

// File: tb/tb_bridge_sched.sv
// Scoreboard bench for bridge_sched with FIFO and APB slave models.
// Timeout scenario runs only when BRIDGE_SCHED_TIMEOUT_EN is defined.
module tb_bridge_sched;
  import bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   wreq_empty_i = 1'b1;
  logic                   wreq_rden_o;
  logic [IW+AW+DW+SW-1:0] wreq_rdata_i = '0;
  logic                   rreq_empty_i = 1'b1;
  logic                   rreq_rden_o;
  logic [IW+AW-1:0]       rreq_rdata_i = '0;
  logic                   bresp_full_i = 1'b0;
  logic                   bresp_wren_o;
  logic [IW+1:0]          bresp_wdata_o;
  logic                   rresp_full_i = 1'b0;
  logic                   rresp_wren_o;
  logic [IW+DW+1:0]       rresp_wdata_o;

  bridge_sched_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

  bridge_sched #(
    .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TIMEOUT_CYC(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wreq_empty_i  (wreq_empty_i),
    .wreq_rden_o   (wreq_rden_o),
    .wreq_rdata_i  (wreq_rdata_i),
    .rreq_empty_i  (rreq_empty_i),
    .rreq_rden_o   (rreq_rden_o),
    .rreq_rdata_i  (rreq_rdata_i),
    .bresp_full_i  (bresp_full_i),
    .bresp_wren_o  (bresp_wren_o),
    .bresp_wdata_o (bresp_wdata_o),
    .rresp_full_i  (rresp_full_i),
    .rresp_wren_o  (rresp_wren_o),
    .rresp_wdata_o (rresp_wdata_o),
    .apb           (apb)
  );

  typedef struct {
    logic        is_w;
    logic [63:0] word;
  } exp_t;

  exp_t  exp_q[$];
  wreq_t wq[$];
  rreq_t rq[$];

  int checks = 0;
  int errors = 0;
  int nresp = 0;
  int acc_n = 0;
  int acc_len = 0;
  int last_len = 0;
  int slv_delay = 0;
  logic slv_err = 1'b0;
  logic slv_hang = 1'b0;
  logic wp, rp;
  logic [63:0] setup_snap;
  exp_t e;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    wreq_empty_i = (wq.size() == 0);
    wreq_rdata_i = (wq.size() != 0) ? wq[0] : '0;
    rreq_empty_i = (rq.size() == 0);
    rreq_rdata_i = (rq.size() != 0) ? rq[0] : '0;
  endtask

  task automatic push_w(input logic [3:0] id, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] r);
    wq.push_back('{id, a, d, s});
    exp_q.push_back('{1'b1, 64'({id, r})});
    refresh();
  endtask

  task automatic push_r(input logic [3:0] id, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] r);
    rq.push_back('{id, a});
    exp_q.push_back('{1'b0, 64'({id, d, r})});
    refresh();
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || wq.size() != 0 || rq.size() != 0 ||
            apb.psel_o) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n < maxc), 1);
  endtask

  // FIFO pop and APB slave models, updated just after each edge
  always @(posedge clk) begin
    wp = wreq_rden_o;
    rp = rreq_rden_o;
    #1;
    if (wp && wq.size() != 0) void'(wq.pop_front());
    if (rp && rq.size() != 0) void'(rq.pop_front());
    refresh();
    apb.pready_i  = 1'b0;
    apb.pslverr_i = 1'b0;
    apb.prdata_i  = '0;
    if (apb.psel_o && apb.penable_o) begin
      if (!slv_hang && acc_n == slv_delay) begin
        apb.pready_i  = 1'b1;
        apb.pslverr_i = slv_err;
        apb.prdata_i  = {16'hBEEF, apb.paddr_o[15:0]};
      end
      acc_n++;
    end else begin
      acc_n = 0;
    end
  end

  // Response monitor and APB stability checker
  always @(negedge clk) begin
    if (apb.psel_o && !apb.penable_o)
      setup_snap = {apb.paddr_o, apb.pwdata_o};
    if (apb.psel_o && apb.penable_o) begin
      acc_len++;
      chk("apb_stable", {apb.paddr_o, apb.pwdata_o}, setup_snap);
    end
    if (bresp_wren_o || rresp_wren_o) begin
      last_len = acc_len;
      acc_len = 0;
      chk("push_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        nresp++;
        chk("resp_kind", 64'(bresp_wren_o), 64'(e.is_w));
        chk("resp_word", bresp_wren_o ? 64'(bresp_wdata_o)
                                      : 64'(rresp_wdata_o), e.word);
      end
    end else if (!(apb.psel_o && apb.penable_o)) begin
      acc_len = 0;
    end
    if (rreq_rden_o) chk("rden_vs_full", 64'(rresp_full_i), 0);
    if (wreq_rden_o) chk("wden_vs_full", 64'(bresp_full_i), 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n;
    refresh();
    apb.pready_i  = 1'b0;
    apb.pslverr_i = 1'b0;
    apb.prdata_i  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {wreq_rden_o, rreq_rden_o, bresp_wren_o,
                    rresp_wren_o, apb.psel_o, apb.penable_o,
                    apb.pwrite_o}, 0);
    chk("rst_paddr", apb.paddr_o, 0);
    chk("rst_pwdata", {apb.pwdata_o, apb.pstrb_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie from reset: W, R, W, R
    push_w(4'd1, 32'h100, 32'h11111111, 4'hF, RESP_OKAY);
    push_r(4'd5, 32'h20, 32'hBEEF0020, RESP_OKAY);
    push_w(4'd2, 32'h104, 32'h22222222, 4'h3, RESP_OKAY);
    push_r(4'd6, 32'h24, 32'hBEEF0024, RESP_OKAY);
    drain("drain_rr", 60);
    chk("rr_count", nresp, 4);

    // Single write, cycle-exact
    @(negedge clk);
    push_w(4'd3, 32'h10, 32'hA5A5A5A5, 4'hF, RESP_OKAY);
    #1;
    chk("c1_rden", wreq_rden_o, 1);
    chk("c1_psel", apb.psel_o, 0);
    @(negedge clk);
    chk("c2_sel_en", {apb.psel_o, apb.penable_o}, 2'b10);
    chk("c2_paddr", apb.paddr_o, 32'h10);
    chk("c2_pwdata", apb.pwdata_o, 32'hA5A5A5A5);
    chk("c2_pstrb_pwrite", {apb.pstrb_o, apb.pwrite_o}, 5'b11111);
    @(negedge clk);
    chk("c3_sel_en", {apb.psel_o, apb.penable_o}, 2'b11);
    chk("c3_bresp", {bresp_wren_o, bresp_wdata_o}, 7'h4C);
    @(negedge clk);
    chk("c4_psel", apb.psel_o, 0);

    // Read, pready after 5 wait cycles, slave error
    slv_delay = 5;
    slv_err = 1'b1;
    push_r(4'd7, 32'h44, 32'hBEEF0044, RESP_SLVERR);
    @(negedge clk);
    @(negedge clk);
    chk("rd_setup_wdata", {apb.pwdata_o, apb.pstrb_o, apb.pwrite_o}, 0);
    drain("drain_slverr", 40);
    chk("rd_access_len", last_len, 6);
    slv_delay = 0;
    slv_err = 1'b0;

    // R-response FIFO full: writes only
    rresp_full_i = 1'b1;
    push_w(4'd8, 32'h200, 32'h0000_8888, 4'h1, RESP_OKAY);
    push_w(4'd10, 32'h204, 32'h0000_AAAA, 4'h2, RESP_OKAY);
    push_r(4'd9, 32'h30, 32'hBEEF0030, RESP_OKAY);
    push_r(4'd11, 32'h34, 32'hBEEF0034, RESP_OKAY);
    repeat (14) @(negedge clk);
    chk("full_rq_held", rq.size(), 2);
    chk("full_wq_done", wq.size(), 0);
    rresp_full_i = 1'b0;
    drain("drain_full", 40);

`ifdef BRIDGE_SCHED_TIMEOUT_EN
    slv_hang = 1'b1;
    push_w(4'd12, 32'h300, 32'h1234, 4'hF, RESP_SLVERR);
    drain("drain_to_w", 40);
    chk("to_w_len", last_len, 8);
    chk("to_w_psel", apb.psel_o, 0);
    push_r(4'd13, 32'h304, 32'h0, RESP_SLVERR);
    drain("drain_to_r", 40);
    chk("to_r_len", last_len, 8);
    slv_hang = 1'b0;
`endif

    // Reset in ACCESS just as pready arrives
    slv_delay = 3;
    wq.push_back('{4'd14, 32'h400, 32'h5555, 4'hF});
    refresh();
    n = 0;
    while (!(apb.psel_o && apb.penable_o) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reach_access", 64'(apb.psel_o && apb.penable_o), 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_no_push", {bresp_wren_o, rresp_wren_o}, 0);
    @(negedge clk);
    chk("rstacc_ctl", {apb.psel_o, apb.penable_o, apb.pwrite_o,
                       wreq_rden_o, rreq_rden_o}, 0);
    chk("rstacc_bus", {apb.paddr_o, apb.pwdata_o}, 0);
    chk("rstacc_strb", apb.pstrb_o, 0);
    rst_n = 1'b1;
    slv_delay = 0;

    // After reset write wins the first tie
    push_r(4'd6, 32'h50, 32'hBEEF0050, RESP_OKAY);
    exp_q.push_front('{1'b1, 64'({4'd15, RESP_OKAY})});
    wq.push_back('{4'd15, 32'h500, 32'h77, 4'h1});
    refresh();
    drain("drain_tie", 40);
`ifdef BRIDGE_SCHED_TIMEOUT_EN
    chk("resp_total", nresp, 14);
`else
    chk("resp_total", nresp, 12);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bridge_sched.md
BRIDGE_SCHED -- requirements
Module: bridge_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width; PSTRB width is DATA_W/8.
REQ-003 SHALL have parameter ID_W, default 4, AXI transaction ID width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 256, maximum number of ACCESS cycles before abort.
REQ-005 SHALL have port clk, input, 1, clock; all logic is sampled on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port wreq_empty_i, input, 1, write-request FIFO empty.
REQ-008 SHALL have port wreq_rden_o, output, 1, write-request FIFO pop.
REQ-009 SHALL have port wreq_rdata_i, input, ID_W+ADDR_W+DATA_W+DATA_W/8, write-request FIFO head {id,addr,wdata,wstrb}.
REQ-010 SHALL have port rreq_empty_i, input, 1, read-request FIFO empty.
REQ-011 SHALL have port rreq_rden_o, output, 1, read-request FIFO pop.
REQ-012 SHALL have port rreq_rdata_i, input, ID_W+ADDR_W, read-request FIFO head {id,addr}.
REQ-013 SHALL have port bresp_full_i, input, 1, B-response FIFO full.
REQ-014 SHALL have port bresp_wren_o and bresp_wdata_o, output, 1 and ID_W+2, B-response FIFO push with {id,resp}.
REQ-015 SHALL have port rresp_full_i, input, 1, R-response FIFO full.
REQ-016 SHALL have port rresp_wren_o and rresp_wdata_o, output, 1 and ID_W+DATA_W+2, R-response FIFO push with {id,rdata,resp}.
REQ-017 SHALL have APB master outputs paddr_o (ADDR_W), psel_o (1), penable_o (1), pwrite_o (1), pwdata_o (DATA_W), pstrb_o (DATA_W/8).
REQ-018 SHALL have APB master inputs prdata_i (DATA_W), pready_i (1), pslverr_i (1).

Function
REQ-019 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-020 SHALL, in IDLE, treat the write request as eligible when !wreq_empty_i & !bresp_full_i, and the read request as eligible when !rreq_empty_i & !rresp_full_i.
REQ-021 SHALL grant the single eligible requester; when both are eligible it SHALL grant the one opposite the last grant (round-robin).
REQ-022 SHALL, on grant, pulse the matching rden_o for one cycle, capture the head word in the same cycle, and go to SETUP.
REQ-023 SHALL drive psel_o=1 and penable_o=0 for exactly one SETUP cycle, then go to ACCESS.
REQ-024 SHALL drive psel_o=1 and penable_o=1 in ACCESS until pready_i=1; paddr, pwrite, pwdata and pstrb SHALL stay stable from SETUP through the end of ACCESS.
REQ-025 SHALL drive pwdata_o and pstrb_o to 0 for reads.
REQ-026 SHALL, in the ACCESS cycle where pready_i=1, push exactly one response (resp=2'b10 if pslverr_i, else 2'b00; reads also carry prdata_i) and return to IDLE.
REQ-027 SHALL achieve a minimum of 3 cycles per transaction (IDLE grant, SETUP, ACCESS); back-to-back grants are allowed.
REQ-028 SHALL never push into a full response FIFO; eligibility at grant guarantees space because this block is the sole writer.

Reset
REQ-029 SHALL, with rst_n=0 at a clock edge, clear all outputs to 0, enter IDLE, and set the last grant to read so that write wins the first tie.
REQ-030 SHALL, on reset during SETUP or ACCESS, drop psel_o on the next cycle and push no response; the popped request is discarded.

Configuration
REQ-031 SHALL, with BRIDGE_SCHED_TIMEOUT_EN defined, count ACCESS cycles; when TIMEOUT_CYC cycles pass without pready_i, it SHALL deassert psel/penable, push a response with resp=2'b10 (rdata=0 for reads), and return to IDLE.
REQ-032 SHALL, without BRIDGE_SCHED_TIMEOUT_EN, wait in ACCESS indefinitely and contain no counter logic.

Structure
REQ-033 SHALL place the state enum, the RESP_OKAY/RESP_SLVERR constants and the packed request/response structs in the shared package bridge_pkg.
REQ-034 SHALL implement the 2-way round-robin in a sub-module bridge_rr_arb (req[1:0], grant[1:0], update strobe).

Verification
REQ-035 SHALL cover: single write {id=3, addr=0x10, data=0xA5A5A5A5, strb=0xF} with pready at the first ACCESS cycle -> psel in cycles 2-3, penable in cycle 3, bresp push {3, 2'b00} in cycle 3.
REQ-036 SHALL cover: both FIFOs non-empty with 2 entries each -> grant order W, R, W, R and 4 responses in that order.
REQ-037 SHALL cover: read with pready delayed 5 cycles and pslverr=1 -> ACCESS lasts 6 cycles and rresp pushes {id, prdata, 2'b10}.
REQ-038 SHALL cover: rresp_full_i=1 with both requests pending -> only writes are granted until full deasserts.
REQ-039 SHALL cover: with BRIDGE_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, pready held at 0 -> abort after 8 ACCESS cycles and push a SLVERR response.
REQ-040 SHALL cover: rst_n pulled low in ACCESS -> all outputs 0 next cycle and no response pushed.
